// File: rtl/button_encoder_if.sv
// Button front-end bundle: raw buttons in, encoded colour code with strobe and
// held echo out. The slave side is the encoder; the master side is the board/consumer.
interface button_encoder_if;
   logic [3:0] BTN;
   logic [1:0] IN;
   logic       IN_VALID;
   logic       BTN_HELD;

   modport master (
      output BTN,
      input  IN,
      input  IN_VALID,
      input  BTN_HELD
   );

   modport slave (
      input  BTN,
      output IN,
      output IN_VALID,
      output BTN_HELD
   );
endinterface

// File: rtl/button_encoder.sv
// Synchronises, debounces and encodes four colour push-buttons into a 2-bit code
// with a single-cycle strobe per accepted press; chords and bounce never strobe.
module button_encoder #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 10
) (
   input logic             CLK,
   input logic             RST_N,
   button_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE_S     = 2'd0,
      PRESS_DB_S = 2'd1,
      HELD_S     = 2'd2,
      REL_DB_S   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic [1:0] code_of(input logic [3:0] v);
      logic [1:0] c;
      case (v)
         4'b0001: c = 2'd0;
         4'b0010: c = 2'd1;
         4'b0100: c = 2'd2;
         4'b1000: c = 2'd3;
         default: c = 2'd0;
      endcase
      return c;
   endfunction

   logic [3:0]       sync1_r;
   logic [3:0]       btn_sync_r;
   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [3:0]       cand_r;
   logic [3:0]       cand_s;
   logic [1:0]       in_r;
   logic [1:0]       in_s;
   logic             in_valid_r;
   logic             in_valid_s;
   logic             btn_held_r;
   logic             btn_held_s;

   // Two-flop synchroniser; every decision below looks only at btn_sync_r.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_r    <= 4'b0000;
         btn_sync_r <= 4'b0000;
      end else begin
         sync1_r    <= bus.BTN;
         btn_sync_r <= sync1_r;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= IDLE_S;
         cnt_r      <= CNT_ZERO;
         cand_r     <= 4'b0000;
         in_r       <= 2'd0;
         in_valid_r <= 1'b0;
         btn_held_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         cand_r     <= cand_s;
         in_r       <= in_s;
         in_valid_r <= in_valid_s;
         btn_held_r <= btn_held_s;
      end
   end

   // Next-state logic; a chord or any disturbance of a held button forces a full
   // debounced release before another press can be considered.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      cand_s     = cand_r;
      in_s       = in_r;
      in_valid_s = 1'b0;
      btn_held_s = btn_held_r;
      case (state_r)
         IDLE_S: begin
            cnt_s = CNT_ZERO;
            if (btn_sync_r == 4'b0000) begin
               state_s = IDLE_S;
            end else if (is_one_hot(btn_sync_r)) begin
               cand_s  = btn_sync_r;
               state_s = PRESS_DB_S;
            end else begin
               state_s = REL_DB_S;
            end
         end
         PRESS_DB_S: begin
            if (btn_sync_r != cand_r) begin
               cnt_s   = CNT_ZERO;
               state_s = IDLE_S;
            end else if (cnt_r == CNT_MAX) begin
               in_s       = code_of(cand_r);
               in_valid_s = 1'b1;
               btn_held_s = 1'b1;
               state_s    = HELD_S;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         HELD_S: begin
            if (btn_sync_r == cand_r) begin
               btn_held_s = 1'b1;
            end else begin
               btn_held_s = 1'b0;
               cnt_s      = CNT_ZERO;
               state_s    = REL_DB_S;
            end
         end
         REL_DB_S: begin
            if (btn_sync_r != 4'b0000) begin
               cnt_s = CNT_ZERO;
            end else if (cnt_r == CNT_MAX) begin
               cnt_s   = CNT_ZERO;
               state_s = IDLE_S;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s    = IDLE_S;
            cnt_s      = CNT_ZERO;
            btn_held_s = 1'b0;
         end
      endcase
   end

   assign bus.IN       = in_r;
   assign bus.IN_VALID = in_valid_r;
   assign bus.BTN_HELD = btn_held_r;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder with a short debounce window of 4 cycles.
module tb_button_encoder;

   logic CLK;
   logic RST_N;

   button_encoder_if bus();

   button_encoder #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (10)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int         checks = 0;
   int         passes = 0;
   int         strobe_cnt;
   int         strobe_edge;
   logic [1:0] strobe_in;
   logic       strobe_held;
   logic       held_seen;

   task automatic clear_obs();
      strobe_cnt  = 0;
      strobe_edge = 0;
      strobe_in   = 2'd0;
      strobe_held = 1'b0;
      held_seen   = 1'b0;
   endtask

   // Advance n edges, sampling 1 time unit after each rising edge.
   task automatic run_cycles(input int n);
      for (int i = 1; i <= n; i++) begin
         @(posedge CLK);
         #1;
         if (bus.IN_VALID === 1'b1) begin
            strobe_cnt  = strobe_cnt + 1;
            strobe_edge = i;
            strobe_in   = bus.IN;
            strobe_held = bus.BTN_HELD;
         end
         if (bus.BTN_HELD === 1'b1) held_seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      RST_N   = 1'b0;
      bus.BTN = 4'b0000;
      #12;
      checks++; if (bus.IN !== 2'd0) $display("FAIL reset_in: got %0d want 0", bus.IN); else passes++;
      checks++; if (bus.IN_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.IN_VALID); else passes++;
      checks++; if (bus.BTN_HELD !== 1'b0) $display("FAIL reset_held: got %b want 0", bus.BTN_HELD); else passes++;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      clear_obs();
      run_cycles(8);
      checks++; if (strobe_cnt !== 0) $display("FAIL idle_no_strobe: got %0d want 0", strobe_cnt); else passes++;
   endtask

   task automatic test_single_press();
      clear_obs();
      bus.BTN = 4'b0100;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t1_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_edge !== 7) $display("FAIL t1_latency: got %0d want 7", strobe_edge); else passes++;
      checks++; if (strobe_in !== 2'd2) $display("FAIL t1_code: got %0d want 2", strobe_in); else passes++;
      checks++; if (strobe_held !== 1'b1) $display("FAIL t1_held_with_strobe: got %b want 1", strobe_held); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(2);
      checks++; if (bus.BTN_HELD !== 1'b1) $display("FAIL t1_held_after_2: got %b want 1", bus.BTN_HELD); else passes++;
      run_cycles(1);
      checks++; if (bus.BTN_HELD !== 1'b0) $display("FAIL t1_held_after_3: got %b want 0", bus.BTN_HELD); else passes++;
      run_cycles(9);
      checks++; if (bus.IN !== 2'd2) $display("FAIL t1_in_kept: got %0d want 2", bus.IN); else passes++;
      checks++; if (strobe_cnt !== 1) $display("FAIL t1_release_strobe: got %0d want 1", strobe_cnt); else passes++;
   endtask

   task automatic test_bounce();
      clear_obs();
      for (int k = 0; k < 6; k++) begin
         bus.BTN = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         run_cycles(2);
      end
      checks++; if (strobe_cnt !== 0) $display("FAIL t2_bounce_strobe: got %0d want 0", strobe_cnt); else passes++;
      bus.BTN = 4'b0001;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t2_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_edge !== 7) $display("FAIL t2_latency: got %0d want 7", strobe_edge); else passes++;
      checks++; if (strobe_in !== 2'd0) $display("FAIL t2_code: got %0d want 0", strobe_in); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(12);
   endtask

   task automatic test_chord();
      clear_obs();
      bus.BTN = 4'b0011;
      run_cycles(10);
      checks++; if (strobe_cnt !== 0) $display("FAIL t3_chord_strobe: got %0d want 0", strobe_cnt); else passes++;
      checks++; if (bus.IN !== 2'd0) $display("FAIL t3_chord_in: got %0d want 0", bus.IN); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(6);
      clear_obs();
      bus.BTN = 4'b1000;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t3_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_edge !== 7) $display("FAIL t3_latency: got %0d want 7", strobe_edge); else passes++;
      checks++; if (strobe_in !== 2'd3) $display("FAIL t3_code: got %0d want 3", strobe_in); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(12);
   endtask

   task automatic test_added_button();
      clear_obs();
      bus.BTN = 4'b0010;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t4_first_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_in !== 2'd1) $display("FAIL t4_first_code: got %0d want 1", strobe_in); else passes++;
      clear_obs();
      bus.BTN = 4'b0110;
      run_cycles(3);
      checks++; if (bus.BTN_HELD !== 1'b0) $display("FAIL t4_held_fall: got %b want 0", bus.BTN_HELD); else passes++;
      run_cycles(7);
      checks++; if (strobe_cnt !== 0) $display("FAIL t4_added_strobe: got %0d want 0", strobe_cnt); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(6);
      clear_obs();
      bus.BTN = 4'b0100;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t4_second_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_edge !== 7) $display("FAIL t4_second_latency: got %0d want 7", strobe_edge); else passes++;
      checks++; if (strobe_in !== 2'd2) $display("FAIL t4_second_code: got %0d want 2", strobe_in); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(12);
   endtask

   task automatic test_release_glitch();
      clear_obs();
      bus.BTN = 4'b0010;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t5_press_count: got %0d want 1", strobe_cnt); else passes++;
      clear_obs();
      bus.BTN = 4'b0000;
      run_cycles(2);
      bus.BTN = 4'b0010;
      run_cycles(2);
      bus.BTN = 4'b0000;
      held_seen = 1'b0;
      run_cycles(4);
      checks++; if (strobe_cnt !== 0) $display("FAIL t5_glitch_strobe: got %0d want 0", strobe_cnt); else passes++;
      checks++; if (held_seen !== 1'b0) $display("FAIL t5_glitch_held: got %b want 0", held_seen); else passes++;
      // Exactly four clean zero cycles must be enough to be back in idle.
      clear_obs();
      bus.BTN = 4'b1000;
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t5_next_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_edge !== 7) $display("FAIL t5_next_latency: got %0d want 7", strobe_edge); else passes++;
      checks++; if (strobe_in !== 2'd3) $display("FAIL t5_next_code: got %0d want 3", strobe_in); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(12);
   endtask

   task automatic test_reset_mid_press();
      clear_obs();
      bus.BTN = 4'b0100;
      run_cycles(4);
      checks++; if (bus.IN !== 2'd3) $display("FAIL t6_pre_in: got %0d want 3", bus.IN); else passes++;
      RST_N = 1'b0;
      #1;
      checks++; if (bus.IN !== 2'd0) $display("FAIL t6_async_in: got %0d want 0", bus.IN); else passes++;
      checks++; if (bus.BTN_HELD !== 1'b0) $display("FAIL t6_async_held: got %b want 0", bus.BTN_HELD); else passes++;
      run_cycles(3);
      checks++; if (strobe_cnt !== 0) $display("FAIL t6_in_reset_strobe: got %0d want 0", strobe_cnt); else passes++;
      RST_N = 1'b1;
      clear_obs();
      run_cycles(20);
      checks++; if (strobe_cnt !== 1) $display("FAIL t6_count: got %0d want 1", strobe_cnt); else passes++;
      checks++; if (strobe_edge !== 7) $display("FAIL t6_latency: got %0d want 7", strobe_edge); else passes++;
      checks++; if (strobe_in !== 2'd2) $display("FAIL t6_code: got %0d want 2", strobe_in); else passes++;
      bus.BTN = 4'b0000;
      run_cycles(12);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_chord();
      test_added_button();
      test_release_glitch();
      test_reset_mid_press();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
